// File: rtl/mmio_button_port.sv
// rtl/mmio_button_port.sv - memory-mapped button status register and LED latch in front of the data RAM
// Mapped addresses are decoded on all 32 bits; everything else passes through to the RAM untouched.
module mmio_button_port #(
  parameter logic [31:0] BTN_ADDR        = 32'd1000,
  parameter logic [31:0] LED_ADDR        = 32'd2000,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        button_raw,
  input  logic [31:0] address_dmem,
  input  logic        wren,
  input  logic [31:0] data,
  input  logic [31:0] q_ram,
  output logic [31:0] q_dmem,
  output logic        ram_wren,
  output logic [31:0] led_out,
  output logic        press_pending
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             btn_db;
  logic             pending;
  logic [CNT_W-1:0] db_cnt;
  logic [7:0]       press_count;

  logic btn_sel;
  logic led_sel;
  logic commit;
  logic press_evt;
  logic clear_req;

  assign btn_sel   = (address_dmem == BTN_ADDR);
  assign led_sel   = (address_dmem == LED_ADDR);
  assign commit    = (sync2 != btn_db) && (db_cnt == CNT_LAST);
  assign press_evt = commit && sync2;
  assign clear_req = wren && btn_sel && data[0];

  assign ram_wren      = wren & ~btn_sel & ~led_sel;
  assign press_pending = pending;

  always_comb begin
    q_dmem = q_ram;
    if (btn_sel) begin
      q_dmem = {16'b0, press_count, 6'b0, btn_db, pending};
    end else if (led_sel) begin
      q_dmem = led_out;
    end
  end

  // Synchronizer and debouncer; any bounce back to the committed level restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= button_raw;
      sync2 <= sync1;
      if (sync2 == btn_db) begin
        db_cnt <= '0;
      end else if (commit) begin
        btn_db <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // A press committing on the same edge as a clear wins, leaving exactly one counted press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending     <= 1'b0;
      press_count <= 8'd0;
    end else if (press_evt) begin
      pending <= 1'b1;
      if (clear_req) begin
        press_count <= 8'd1;
      end else if (press_count != 8'hFF) begin
        press_count <= press_count + 8'd1;
      end
    end else if (clear_req) begin
      pending     <= 1'b0;
      press_count <= 8'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_out <= 32'd0;
    end else if (wren && led_sel) begin
      led_out <= data;
    end
  end

endmodule

// File: tb/tb_mmio_button_port.sv
// tb/tb_mmio_button_port.sv - directed self-checking bench for mmio_button_port
// Inputs change and outputs are sampled on the falling edge, half a period from the active edge.
module tb_mmio_button_port;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        button_raw = 1'b0;
  logic [31:0] address_dmem = 32'd1000;
  logic        wren = 1'b0;
  logic [31:0] data = 32'd0;
  logic [31:0] q_ram = 32'd0;
  logic [31:0] q_dmem;
  logic        ram_wren;
  logic [31:0] led_out;
  logic        press_pending;

  int total = 0;
  int bad = 0;

  mmio_button_port #(
    .BTN_ADDR(32'd1000),
    .LED_ADDR(32'd2000),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .button_raw(button_raw),
    .address_dmem(address_dmem),
    .wren(wren),
    .data(data),
    .q_ram(q_ram),
    .q_dmem(q_dmem),
    .ram_wren(ram_wren),
    .led_out(led_out),
    .press_pending(press_pending)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #2;
    total++; if (q_dmem !== 32'h0) begin bad++; $display("FAIL reset_status got=%h want=%h", q_dmem, 32'h0); end
    total++; if (led_out !== 32'h0) begin bad++; $display("FAIL reset_led got=%h want=%h", led_out, 32'h0); end
    total++; if (press_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b want=0", press_pending); end
    total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL reset_ram_wren got=%b want=0", ram_wren); end
    cyc(1);
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_clean_press;
    address_dmem = 32'd1000;
    button_raw = 1'b1;
    cyc(5);
    total++; if (q_dmem !== 32'h0) begin bad++; $display("FAIL press_early got=%h want=%h", q_dmem, 32'h0); end
    cyc(1);
    total++; if (q_dmem !== 32'h103) begin bad++; $display("FAIL press_commit got=%h want=%h", q_dmem, 32'h103); end
    total++; if (press_pending !== 1'b1) begin bad++; $display("FAIL press_pending got=%b want=1", press_pending); end
  endtask

  task automatic test_clear;
    wren = 1'b1; data = 32'hFFFF_FFFE;
    total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL btn_store_ram_wren got=%b want=0", ram_wren); end
    cyc(1);
    total++; if (q_dmem !== 32'h103) begin bad++; $display("FAIL clear_bit0_zero got=%h want=%h", q_dmem, 32'h103); end
    data = 32'h1;
    cyc(1);
    wren = 1'b0; data = 32'h0;
    total++; if (q_dmem !== 32'h2) begin bad++; $display("FAIL clear_held got=%h want=%h", q_dmem, 32'h2); end
    button_raw = 1'b0;
    cyc(5);
    total++; if (q_dmem !== 32'h2) begin bad++; $display("FAIL release_early got=%h want=%h", q_dmem, 32'h2); end
    cyc(1);
    total++; if (q_dmem !== 32'h0) begin bad++; $display("FAIL release_commit got=%h want=%h", q_dmem, 32'h0); end
  endtask

  task automatic test_collision;
    button_raw = 1'b1; cyc(6);
    total++; if (q_dmem !== 32'h103) begin bad++; $display("FAIL second_press got=%h want=%h", q_dmem, 32'h103); end
    button_raw = 1'b0; cyc(6);
    total++; if (q_dmem !== 32'h101) begin bad++; $display("FAIL second_release got=%h want=%h", q_dmem, 32'h101); end
    button_raw = 1'b1; cyc(5);
    wren = 1'b1; data = 32'h1;
    cyc(1);
    wren = 1'b0; data = 32'h0;
    total++; if (q_dmem !== 32'h103) begin bad++; $display("FAIL collision got=%h want=%h", q_dmem, 32'h103); end
    button_raw = 1'b0; cyc(6);
  endtask

  task automatic test_glitch;
    wren = 1'b1; data = 32'h1; cyc(1); wren = 1'b0; data = 32'h0;
    total++; if (q_dmem !== 32'h0) begin bad++; $display("FAIL glitch_pre_clear got=%h want=%h", q_dmem, 32'h0); end
    button_raw = 1'b1; cyc(3); button_raw = 1'b0; cyc(10);
    total++; if (q_dmem !== 32'h0) begin bad++; $display("FAIL glitch_3cyc got=%h want=%h", q_dmem, 32'h0); end
    total++; if (press_pending !== 1'b0) begin bad++; $display("FAIL glitch_pending got=%b want=0", press_pending); end
    button_raw = 1'b1; cyc(4); button_raw = 1'b0; cyc(10);
    total++; if (q_dmem !== 32'h101) begin bad++; $display("FAIL pulse_4cyc got=%h want=%h", q_dmem, 32'h101); end
  endtask

  task automatic test_led;
    address_dmem = 32'd2000; wren = 1'b1; data = 32'hDEAD_BEEF;
    total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL led_ram_wren got=%b want=0", ram_wren); end
    cyc(1);
    wren = 1'b0; data = 32'h0;
    total++; if (led_out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL led_latch got=%h want=%h", led_out, 32'hDEAD_BEEF); end
    total++; if (q_dmem !== 32'hDEAD_BEEF) begin bad++; $display("FAIL led_read got=%h want=%h", q_dmem, 32'hDEAD_BEEF); end
    address_dmem = 32'd5; wren = 1'b1; data = 32'h1111_2222; q_ram = 32'h1234_5678;
    #1;
    total++; if (ram_wren !== 1'b1) begin bad++; $display("FAIL ram_store_wren got=%b want=1", ram_wren); end
    total++; if (q_dmem !== 32'h1234_5678) begin bad++; $display("FAIL ram_read0 got=%h want=%h", q_dmem, 32'h1234_5678); end
    q_ram = 32'h0000_A5A5;
    #1;
    total++; if (q_dmem !== 32'h0000_A5A5) begin bad++; $display("FAIL ram_read1 got=%h want=%h", q_dmem, 32'h0000_A5A5); end
    address_dmem = 32'h0001_03E8;
    #1;
    total++; if (ram_wren !== 1'b1) begin bad++; $display("FAIL alias_wren got=%b want=1", ram_wren); end
    total++; if (q_dmem !== 32'h0000_A5A5) begin bad++; $display("FAIL alias_read got=%h want=%h", q_dmem, 32'h0000_A5A5); end
    cyc(1);
    wren = 1'b0; data = 32'h0;
    total++; if (led_out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL led_hold got=%h want=%h", led_out, 32'hDEAD_BEEF); end
    address_dmem = 32'd1000;
  endtask

  task automatic test_saturation;
    wren = 1'b1; data = 32'h1; cyc(1); wren = 1'b0; data = 32'h0;
    for (int i = 0; i < 300; i++) begin
      button_raw = 1'b1; cyc(6);
      button_raw = 1'b0; cyc(6);
    end
    total++; if (q_dmem !== 32'h0000_FF01) begin bad++; $display("FAIL saturate got=%h want=%h", q_dmem, 32'h0000_FF01); end
    total++; if (press_pending !== 1'b1) begin bad++; $display("FAIL saturate_pending got=%b want=1", press_pending); end
  endtask

  task automatic test_async_reset;
    address_dmem = 32'd2000; wren = 1'b1; data = 32'h55; cyc(1);
    wren = 1'b0; data = 32'h0;
    total++; if (led_out !== 32'h55) begin bad++; $display("FAIL led_55 got=%h want=%h", led_out, 32'h55); end
    address_dmem = 32'd1000;
    button_raw = 1'b1;
    cyc(4);
    #2 reset = 1'b1;
    #1;
    total++; if (led_out !== 32'h0) begin bad++; $display("FAIL areset_led got=%h want=%h", led_out, 32'h0); end
    total++; if (press_pending !== 1'b0) begin bad++; $display("FAIL areset_pending got=%b want=0", press_pending); end
    total++; if (q_dmem !== 32'h0) begin bad++; $display("FAIL areset_status got=%h want=%h", q_dmem, 32'h0); end
    cyc(1);
    reset = 1'b0;
    cyc(5);
    total++; if (q_dmem !== 32'h0) begin bad++; $display("FAIL post_reset_early got=%h want=%h", q_dmem, 32'h0); end
    cyc(1);
    total++; if (q_dmem !== 32'h103) begin bad++; $display("FAIL post_reset_commit got=%h want=%h", q_dmem, 32'h103); end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_clear;
    test_collision;
    test_glitch;
    test_led;
    test_saturation;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
